vga_text_model: RTL and testbench
=================================

VGA_TEXT_MODEL -- requirements
Module: vga_text_model

Interface
REQ-001 Parameter h_disp, default 1280, visible pixels per line; h_chars = h_disp/8.
REQ-002 Parameter v_disp, default 1024, visible lines; v_chars = v_disp/8, max_chars = h_chars*v_chars, char_addr_width = $clog2(max_chars).
REQ-003 Parameter BLINK_BITS, default 24, cursor blink counter width; used only with VGA_TEXT_CURSOR_EN.
REQ-004 Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_char  in  8  character or control code.
- in_valid  in  1  in_char valid.
- in_ready  out  1  block accepts in_char this cycle.
- addr_read  in  char_addr_width  display read address.
- char_read  out  8  character at addr_read.
- addr_init  in  char_addr_width  address of top screen line.
- scroll  out  1  one-cycle request to advance addr_init.
- cursor_addr  out  char_addr_width  current write cell.

Function
REQ-005 Storage is a circular buffer of max_chars 8-bit cells.
- Read port is synchronous: char_read is registered 1 cycle after addr_read.
- On a same-address read/write in one cycle, the read returns the old data.
REQ-006 FSM states:
- CLR_ALL: entered on reset; writes 0x20 to cells 0..max_chars-1, one cell per cycle; goes to IDLE after the last cell.
- IDLE: in_ready=1.
- CLR_LINE: writes 0x20 to h_chars cells starting at clr_base, then returns to IDLE.
- in_ready=0 in every state except IDLE.
REQ-007 A transfer occurs when in_valid && in_ready. The character is consumed and acted on in that same cycle.
REQ-008 Cursor state:
- col: 0..h_chars-1.
- row: 0..v_chars-1, counted relative to the top screen line.
- line_base: address of the cursor's line.
- cursor_addr = line_base + col, kept below max_chars by wrap.
REQ-009 Printable characters 0x20-0x7E:
- Write in_char to cursor_addr.
- If col < h_chars-1, increment col.
- Otherwise perform a line advance (REQ-012).
REQ-010 0x0A: line advance. 0x0D: col = 0.
REQ-011 0x08: if col > 0, decrement col and write 0x20 at the new cursor_addr; if col = 0, no change.
- All other codes are consumed with no effect.
REQ-012 Line advance:
- col = 0.
- line_base += h_chars; if the result is >= max_chars, it wraps by subtracting max_chars.
- If row < v_chars-1, increment row.
- Otherwise:
  - row is held.
  - scroll pulses high for exactly 1 cycle.
  - clr_base = addr_init sampled that cycle.
  - line_base = clr_base.
  - FSM enters CLR_LINE.
REQ-013 After a scroll, addr_init is expected to advance (by h_chars) before the next scroll. The block does not check this.

Reset
REQ-014 While rst=1, the following hold:
- in_ready=0, scroll=0, char_read=0x00.
- cursor_addr=0, col=0, row=0, line_base=0.
- FSM state = CLR_ALL, clear index=0.
- Blink counter = 0.
REQ-015 rst asserted mid-operation (including during CLR_LINE) aborts the operation and restarts CLR_ALL.
- in_ready first rises exactly max_chars cycles after rst falls.

Configuration
REQ-016 Macro VGA_TEXT_CURSOR_EN.
- Defined:
  - A BLINK_BITS free-running counter runs.
  - When addr_read (registered) equals cursor_addr and the counter MSB is 1, char_read = 0x5F.
  - Otherwise char_read is the stored cell.
- Undefined: no counter is built, and char_read is always the stored cell.

Structure
REQ-017 Package vga_text_pkg holds:
- Code constants: CH_SPACE=0x20, CH_LF=0x0A, CH_CR=0x0D, CH_BS=0x08, CH_CURSOR=0x5F.
- The FSM state enum.
REQ-018 Sub-module char_ram holds the storage: one write port and one synchronous read port, parameterized depth and address width.
- All cursor and FSM logic stays in vga_text_model.

Verification
Scenarios use the defaults: h_chars=160, v_chars=128, max_chars=20480.
REQ-019 Reset release: in_ready=0 for 20480 cycles, then 1; reading any address, e.g. 0x4FFF, gives 0x20.
REQ-020 Send "AB", 0x0D, "C": cell 0=0x43 ('C'), cell 1=0x42 ('B'), cursor_addr=1.
REQ-021 Send 160 × 'x': cells 0..159=0x78, col=0, cursor_addr=160, row=1, scroll never asserted.
REQ-022 Send 0x0A ×127, then 0x0A with addr_init=0:
- scroll=1 for exactly 1 cycle.
- in_ready=0 for 160 cycles.
- cells 0..159 = 0x20.
- cursor_addr=0.
REQ-023 Send 'Q', 0x08, then 0x08 again: cell 0=0x20, cursor_addr=0 after both; hold in_valid=1 with in_ready=0 during CLR_LINE and verify no character is lost.
REQ-024 With VGA_TEXT_CURSOR_EN, BLINK_BITS=4, addr_read=cursor_addr: char_read toggles between 0x5F and the stored cell every 8 cycles.

Source files
------------

// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared constants and FSM state type for the VGA text-mode model.
//   Character codes: CH_SPACE, CH_LF, CH_CR, CH_BS, CH_CURSOR.
//   vga_state_e: StClrAll (full-screen clear), StIdle (accepting), StClrLine (scroll clear).
package vga_text_pkg;

   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_LF     = 8'h0A;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_BS     = 8'h08;
   localparam logic [7:0] CH_CURSOR = 8'h5F;

   typedef enum logic [1:0] {
      StClrAll,
      StIdle,
      StClrLine
   } vga_state_e;

endpackage

// File: rtl/char_ram.sv
// char_ram: character cell storage, one write port and one synchronous read port.
// Ports:
//   clk          clock
//   rst          synchronous active-high reset (clears the read data register only)
//   we/waddr/wdata  write port
//   raddr        read address
//   rdata        cell at raddr, registered one cycle; a same-cycle write returns old data
module char_ram #(
   parameter int unsigned depth      = 20480,
   parameter int unsigned addr_width = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [addr_width-1:0] waddr,
   input  logic [7:0]            wdata,
   input  logic [addr_width-1:0] raddr,
   output logic [7:0]            rdata
);

   logic [7:0] mem [depth];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= 8'h00;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/vga_text_model.sv
// vga_text_model: text-mode character buffer with cursor, line wrap and scroll.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_char       character or control code (LF, CR, BS handled; other non-printables ignored)
//   in_valid/in_ready  input handshake; in_ready only in idle
//   addr_read     display read address; char_read follows one cycle later
//   addr_init     address of the top screen line, sampled when a scroll happens
//   scroll        one-cycle request for the display to advance addr_init
//   cursor_addr   cell the next printable character goes to
// Optional feature: define VGA_TEXT_CURSOR_EN to overlay a blinking '_' at the cursor cell.
module vga_text_model
   import vga_text_pkg::*;
#(
   parameter int unsigned h_disp     = 1280,
   parameter int unsigned v_disp     = 1024,
   parameter int unsigned BLINK_BITS = 24,
   localparam int unsigned h_chars         = h_disp / 8,
   localparam int unsigned v_chars         = v_disp / 8,
   localparam int unsigned max_chars       = h_chars * v_chars,
   localparam int unsigned char_addr_width = $clog2(max_chars)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 in_char,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [char_addr_width-1:0] addr_read,
   output logic [7:0]                 char_read,
   input  logic [char_addr_width-1:0] addr_init,
   output logic                       scroll,
   output logic [char_addr_width-1:0] cursor_addr
);

   localparam int unsigned AW   = char_addr_width;
   localparam int unsigned ColW = (h_chars > 1) ? $clog2(h_chars) : 1;
   localparam int unsigned RowW = (v_chars > 1) ? $clog2(v_chars) : 1;

   localparam logic [ColW-1:0] ColLast     = ColW'(h_chars - 1);
   localparam logic [RowW-1:0] RowLast     = RowW'(v_chars - 1);
   localparam logic [AW-1:0]   AddrLast    = AW'(max_chars - 1);
   localparam logic [AW-1:0]   LineLastIdx = AW'(h_chars - 1);
   localparam logic [AW-1:0]   LineStep    = AW'(h_chars);
   localparam logic [AW:0]     MaxCharsExt = (AW + 1)'(max_chars);

   // Modular add within the circular buffer; operands are always below max_chars.
   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base,
                                              input logic [AW-1:0] off);
      logic [AW:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= MaxCharsExt) begin
         sum = sum - MaxCharsExt;
      end
      return sum[AW-1:0];
   endfunction

   vga_state_e      state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [ColW-1:0] col_q, col_d;
   logic [RowW-1:0] row_q, row_d;
   logic [AW-1:0]   line_base_q, line_base_d;
   logic [AW-1:0]   clr_base_q, clr_base_d;

   logic            ram_we;
   logic [AW-1:0]   ram_waddr;
   logic [7:0]      ram_wdata;
   logic [7:0]      ram_rdata;
   logic            scroll_c;
   logic            advance;

   assign cursor_addr = wrap_add(line_base_q, AW'(col_q));
   // rst is folded in so the handshake and scroll are quiet from the first reset cycle.
   assign in_ready    = (state_q == StIdle) && !rst;
   assign scroll      = scroll_c && !rst;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      col_d       = col_q;
      row_d       = row_q;
      line_base_d = line_base_q;
      clr_base_d  = clr_base_q;
      ram_we      = 1'b0;
      ram_waddr   = cursor_addr;
      ram_wdata   = CH_SPACE;
      scroll_c    = 1'b0;
      advance     = 1'b0;

      unique case (state_q)
         StClrAll: begin
            ram_we    = 1'b1;
            ram_waddr = idx_q;
            if (idx_q == AddrLast) begin
               state_d = StIdle;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StClrLine: begin
            ram_we    = 1'b1;
            ram_waddr = wrap_add(clr_base_q, idx_q);
            if (idx_q == LineLastIdx) begin
               state_d = StIdle;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StIdle: begin
            if (in_valid) begin
               if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                  ram_we    = 1'b1;
                  ram_wdata = in_char;
                  if (col_q != ColLast) begin
                     col_d = col_q + 1'b1;
                  end else begin
                     advance = 1'b1;
                  end
               end else if (in_char == CH_LF) begin
                  advance = 1'b1;
               end else if (in_char == CH_CR) begin
                  col_d = '0;
               end else if (in_char == CH_BS) begin
                  if (col_q != '0) begin
                     col_d     = col_q - 1'b1;
                     ram_we    = 1'b1;
                     ram_waddr = wrap_add(line_base_q, AW'(col_q - 1'b1));
                  end
               end

               if (advance) begin
                  col_d = '0;
                  if (row_q != RowLast) begin
                     row_d       = row_q + 1'b1;
                     line_base_d = wrap_add(line_base_q, LineStep);
                  end else begin
                     // Bottom line: the display owns the top-line pointer, so restart
                     // writing at the line it is about to drop and clear it first.
                     scroll_c    = 1'b1;
                     clr_base_d  = addr_init;
                     line_base_d = addr_init;
                     idx_d       = '0;
                     state_d     = StClrLine;
                  end
               end
            end
         end
         default: state_d = StClrAll;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StClrAll;
         idx_q       <= '0;
         col_q       <= '0;
         row_q       <= '0;
         line_base_q <= '0;
         clr_base_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         col_q       <= col_d;
         row_q       <= row_d;
         line_base_q <= line_base_d;
         clr_base_q  <= clr_base_d;
      end
   end

   char_ram #(
      .depth      (max_chars),
      .addr_width (AW)
   ) u_char_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we && !rst),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (addr_read),
      .rdata (ram_rdata)
   );

`ifdef VGA_TEXT_CURSOR_EN
   logic [BLINK_BITS-1:0] blink_q;
   logic [AW-1:0]         addr_read_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_q     <= '0;
         addr_read_q <= '0;
      end else begin
         blink_q     <= blink_q + 1'b1;
         addr_read_q <= addr_read;
      end
   end

   assign char_read = (addr_read_q == cursor_addr && blink_q[BLINK_BITS-1]) ? CH_CURSOR
                                                                             : ram_rdata;
`else
   logic unused_blink_bits;
   assign unused_blink_bits = (BLINK_BITS != 0);
   assign char_read = ram_rdata;
`endif

endmodule

// File: tb/tb_vga_text_model.sv
// tb_vga_text_model: directed self-checking bench for vga_text_model at default geometry
// (160 x 128 cells, 20480-cell buffer).
module tb_vga_text_model;

   localparam int AW = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    in_char;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] addr_read;
   logic [7:0]    char_read;
   logic [AW-1:0] addr_init;
   logic          scroll;
   logic [AW-1:0] cursor_addr;

   int checks = 0;
   int errors = 0;
   int scroll_cnt = 0;

   always #5 clk = ~clk;

   vga_text_model #(
      .h_disp     (1280),
      .v_disp     (1024),
      .BLINK_BITS (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_char     (in_char),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .addr_read   (addr_read),
      .char_read   (char_read),
      .addr_init   (addr_init),
      .scroll      (scroll),
      .cursor_addr (cursor_addr)
   );

   always @(negedge clk) begin
      if (scroll === 1'b1) scroll_cnt++;
   end

   task automatic send_char(input logic [7:0] c);
      int n = 0;
      while (in_ready !== 1'b1 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_char_timeout: in_ready=%b required 1", in_ready);
      end
      in_char  = c;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic read_cell(input logic [AW-1:0] a, output logic [7:0] d);
      addr_read = a;
      @(posedge clk); #1;
      d = char_read;
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (in_ready !== 1'b1 && cnt < 30000) begin
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   task automatic test_reset;
      logic [7:0] d;
      int cnt;
      rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; addr_read = '0; addr_init = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
      checks++; if (scroll !== 1'b0) begin errors++; $display("FAIL rst_scroll: got %b required 0", scroll); end
      checks++; if (char_read !== 8'h00) begin errors++; $display("FAIL rst_char_read: got %h required 00", char_read); end
      checks++; if (cursor_addr !== 15'd0) begin errors++; $display("FAIL rst_cursor: got %0d required 0", cursor_addr); end
      rst = 1'b0;
      wait_ready(cnt);
      checks++; if (cnt != 20480) begin errors++; $display("FAIL rst_clear_cycles: got %0d required 20480", cnt); end
      read_cell(15'h4FFF, d);
      checks++; if (d !== 8'h20) begin errors++; $display("FAIL rst_cell_4fff: got %h required 20", d); end
      read_cell(15'd0, d);
      checks++; if (d !== 8'h20) begin errors++; $display("FAIL rst_cell_0: got %h required 20", d); end
   endtask

   task automatic test_print_cr;
      logic [7:0] d;
      send_char(8'h41); send_char(8'h42); send_char(8'h0D); send_char(8'h43);
      read_cell(15'd0, d);
      checks++; if (d !== 8'h43) begin errors++; $display("FAIL cr_cell0: got %h required 43", d); end
      read_cell(15'd1, d);
      checks++; if (d !== 8'h42) begin errors++; $display("FAIL cr_cell1: got %h required 42", d); end
      checks++; if (cursor_addr !== 15'd1) begin errors++; $display("FAIL cr_cursor: got %0d required 1", cursor_addr); end
   endtask

   task automatic test_line_wrap;
      logic [7:0] d;
      // Cursor sits at col 1 from the previous scenario; CR returns it to cell 0.
      send_char(8'h0D);
      for (int i = 0; i < 160; i++) send_char(8'h78);
      read_cell(15'd0, d);
      checks++; if (d !== 8'h78) begin errors++; $display("FAIL wrap_cell0: got %h required 78", d); end
      read_cell(15'd159, d);
      checks++; if (d !== 8'h78) begin errors++; $display("FAIL wrap_cell159: got %h required 78", d); end
      read_cell(15'd160, d);
      checks++; if (d !== 8'h20) begin errors++; $display("FAIL wrap_cell160: got %h required 20", d); end
      checks++; if (cursor_addr !== 15'd160) begin errors++; $display("FAIL wrap_cursor: got %0d required 160", cursor_addr); end
      checks++; if (dut.row_q !== 7'd1) begin errors++; $display("FAIL wrap_row: got %0d required 1", dut.row_q); end
      checks++; if (scroll_cnt != 0) begin errors++; $display("FAIL wrap_scroll: got %0d pulses required 0", scroll_cnt); end
   endtask

   task automatic test_scroll;
      logic [7:0] d;
      int cnt;
      // Row 1 now; 126 line feeds reach the bottom row (127).
      for (int i = 0; i < 126; i++) send_char(8'h0A);
      checks++; if (cursor_addr !== 15'd20320) begin errors++; $display("FAIL scroll_bottom: got %0d required 20320", cursor_addr); end
      addr_init = 15'd0;
      in_char = 8'h0A; in_valid = 1'b1;
      #1;
      checks++; if (scroll !== 1'b1) begin errors++; $display("FAIL scroll_pulse: got %b required 1", scroll); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (scroll !== 1'b0) begin errors++; $display("FAIL scroll_drop: got %b required 0", scroll); end
      wait_ready(cnt);
      checks++; if (cnt != 160) begin errors++; $display("FAIL scroll_busy: got %0d cycles required 160", cnt); end
      checks++; if (scroll_cnt != 1) begin errors++; $display("FAIL scroll_count: got %0d required 1", scroll_cnt); end
      checks++; if (cursor_addr !== 15'd0) begin errors++; $display("FAIL scroll_cursor: got %0d required 0", cursor_addr); end
      read_cell(15'd0, d);
      checks++; if (d !== 8'h20) begin errors++; $display("FAIL scroll_cell0: got %h required 20", d); end
      read_cell(15'd159, d);
      checks++; if (d !== 8'h20) begin errors++; $display("FAIL scroll_cell159: got %h required 20", d); end
   endtask

   task automatic test_backspace_hold;
      logic [7:0] d;
      int cnt;
      send_char(8'h51);
      read_cell(15'd0, d);
      checks++; if (d !== 8'h51) begin errors++; $display("FAIL bs_q_written: got %h required 51", d); end
      send_char(8'h08);
      checks++; if (cursor_addr !== 15'd0) begin errors++; $display("FAIL bs_cursor1: got %0d required 0", cursor_addr); end
      send_char(8'h08);
      checks++; if (cursor_addr !== 15'd0) begin errors++; $display("FAIL bs_cursor2: got %0d required 0", cursor_addr); end
      read_cell(15'd0, d);
      checks++; if (d !== 8'h20) begin errors++; $display("FAIL bs_cell0: got %h required 20", d); end
      // Scroll again, keeping 'Z' offered through the whole line clear.
      addr_init = 15'd160;
      in_char = 8'h0A; in_valid = 1'b1;
      @(posedge clk); #1;
      in_char = 8'h5A;
      cnt = 0;
      while (in_ready !== 1'b1 && cnt < 1000) begin
         @(posedge clk); #1;
         cnt++;
      end
      checks++; if (cnt != 160) begin errors++; $display("FAIL hold_busy: got %0d cycles required 160", cnt); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (cursor_addr !== 15'd161) begin errors++; $display("FAIL hold_cursor: got %0d required 161", cursor_addr); end
      read_cell(15'd160, d);
      checks++; if (d !== 8'h5A) begin errors++; $display("FAIL hold_cell160: got %h required 5a", d); end
      read_cell(15'd161, d);
      checks++; if (d !== 8'h20) begin errors++; $display("FAIL hold_cell161: got %h required 20", d); end
      checks++; if (scroll_cnt != 2) begin errors++; $display("FAIL hold_scroll_count: got %0d required 2", scroll_cnt); end
   endtask

   task automatic test_reset_mid_clear;
      logic [7:0] d;
      int cnt;
      addr_init = 15'd320;
      send_char(8'h0A);
      repeat (50) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", in_ready); end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (cursor_addr !== 15'd0) begin errors++; $display("FAIL mid_rst_cursor: got %0d required 0", cursor_addr); end
      checks++; if (char_read !== 8'h00) begin errors++; $display("FAIL mid_rst_char_read: got %h required 00", char_read); end
      rst = 1'b0;
      wait_ready(cnt);
      checks++; if (cnt != 20480) begin errors++; $display("FAIL mid_clear_cycles: got %0d required 20480", cnt); end
      read_cell(15'd160, d);
      checks++; if (d !== 8'h20) begin errors++; $display("FAIL mid_cell160: got %h required 20", d); end
   endtask

`ifdef VGA_TEXT_CURSOR_EN
   task automatic test_cursor_blink;
      logic [7:0] s [40];
      int i0;
      addr_read = 15'd0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         s[i] = char_read;
      end
      i0 = 0;
      for (int i = 2; i < 20; i++) begin
         if (i0 == 0 && s[i] !== s[i-1]) i0 = i;
      end
      checks++;
      if (!((s[i0-1] === 8'h5F && s[i0] === 8'h20) || (s[i0-1] === 8'h20 && s[i0] === 8'h5F)))
         begin errors++; $display("FAIL blink_values: got %h/%h required 5f/20 pair", s[i0-1], s[i0]); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (s[i0+k] !== ((k / 8) % 2 == 0 ? s[i0] : s[i0-1])) begin
            errors++;
            $display("FAIL blink_period[%0d]: got %h", k, s[i0+k]);
         end
      end
   endtask
`endif

   initial begin
      test_reset;
      test_print_cr;
      test_line_wrap;
      test_scroll;
      test_backspace_hold;
      test_reset_mid_clear;
`ifdef VGA_TEXT_CURSOR_EN
      test_cursor_blink;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
